// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment BCD display back end:
// converter states, segment patterns and the binary/BCD widths.
package ssd_pkg;

    localparam int BIN_W    = 13;               // binary input width, 0..8191
    localparam int BCD_W    = 16;               // four BCD nibbles
    localparam int SHIFT_W  = BCD_W + BIN_W;    // double-dabble working register
    localparam int CNT_W    = 4;                // enough to count BIN_W shifts
    localparam int LAST_CNT = BIN_W - 1;        // index of the final shift

    // Converter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } conv_state_e;

    // Active-low segment patterns, {a,b,c,d,e,f,g} with a at bit 6
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Map one BCD nibble to its segment pattern; non-decimal codes go dark
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Double-dabble correction: add 3 to every nibble that is 5 or more so
    // the following left shift carries correctly into the next decade
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        logic [3:0]       nib;
        res = '0;
        for (int i = 0; i < BCD_W / 4; i++) begin
            nib = bcd[i*4 +: 4];
            if (nib >= 4'd5) begin
                nib = nib + 4'd3;
            end
            res[i*4 +: 4] = nib;
        end
        return res;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter. A change on value_in seen while idle
// starts a 13-shift conversion; the finished BCD is published in one step so
// a partial result is never visible on bcd_out.
module bin2bcd_seq
    import ssd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,        // asynchronous, active low
    input  logic [BIN_W-1:0] value_in,
    output logic [BCD_W-1:0] bcd_out,
    output logic             busy
);

    conv_state_e        state_q, state_d;
    logic [BIN_W-1:0]   val_q,   val_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [BCD_W-1:0]   bcd_q,   bcd_d;
    logic               busy_q,  busy_d;
    logic [SHIFT_W-1:0] adjusted;

    // Next-state logic: IDLE watches for a new value, CONV adjusts and
    // shifts once per cycle, LOAD publishes the finished BCD digits
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        val_d    = val_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        adjusted = {dabble_adjust(shift_q[SHIFT_W-1 -: BCD_W]), shift_q[BIN_W-1:0]};

        case (state_q)
            IDLE: begin
                if (value_in != val_q) begin
                    val_d   = value_in;
                    shift_d = {{BCD_W{1'b0}}, value_in};
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                shift_d = adjusted << 1;
                if (cnt_q == CNT_W'(LAST_CNT)) begin
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOAD: begin
                bcd_d   = shift_q[SHIFT_W-1 -: BCD_W];
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Converter state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            val_q   <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q <= state_d;
            val_q   <= val_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
        end
    end

    assign bcd_out = bcd_q;
    assign busy    = busy_q;

endmodule

// File: rtl/ssd_bcd_driver.sv
// Four-digit seven-segment back end: converts the datapath's display value to
// BCD and time-multiplexes the digits onto active-low anodes and segments.
module ssd_bcd_driver
    import ssd_pkg::*;
#(
    parameter int REFRESH_BITS = 18,    // scan counter width; top 2 bits pick the digit
    parameter bit BLANK_LZ     = 1'b1   // blank leading zeros (digit 0 always shown)
) (
    input  logic             clk,
    input  logic             rst,       // asynchronous, active low
    input  logic [BIN_W-1:0] value_in,
    output logic [BCD_W-1:0] bcd_out,
    output logic             busy,
    output logic [3:0]       ANODES,
    output logic [6:0]       LED_OUT
);

    logic [REFRESH_BITS-1:0] scan_cnt_q, scan_cnt_d;
    logic [3:0]              anodes_q,   anodes_d;
    logic [6:0]              led_q,      led_d;
    logic [1:0]              dsel;
    logic [3:0]              digit;
    logic                    blank;
    logic [3:1]              zero_above; // digit i and all higher digits are zero

    bin2bcd_seq u_conv (
        .clk      (clk),
        .rst      (rst),
        .value_in (value_in),
        .bcd_out  (bcd_out),
        .busy     (busy)
    );

    assign dsel = scan_cnt_q[REFRESH_BITS-1 -: 2];

    // Select the active digit, decide blanking and form the next display outputs
    always_comb begin
        scan_cnt_d = scan_cnt_q + REFRESH_BITS'(1);

        zero_above[3] = (bcd_out[15:12] == 4'd0);
        zero_above[2] = zero_above[3] && (bcd_out[11:8] == 4'd0);
        zero_above[1] = zero_above[2] && (bcd_out[7:4]  == 4'd0);

        case (dsel)
            2'd0:    begin digit = bcd_out[3:0];   blank = 1'b0;          end
            2'd1:    begin digit = bcd_out[7:4];   blank = zero_above[1]; end
            2'd2:    begin digit = bcd_out[11:8];  blank = zero_above[2]; end
            default: begin digit = bcd_out[15:12]; blank = zero_above[3]; end
        endcase

        anodes_d = ~(4'b0001 << dsel);
        led_d    = (BLANK_LZ && blank) ? SEG_BLANK : seg_decode(digit);
    end

    // Free-running scan counter and registered display outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt_q <= '0;
            anodes_q   <= 4'b1111;
            led_q      <= SEG_BLANK;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            anodes_q   <= anodes_d;
            led_q      <= led_d;
        end
    end

    assign ANODES  = anodes_q;
    assign LED_OUT = led_q;

endmodule

// File: tb/tb_ssd_bcd_driver.sv
// Bench for ssd_bcd_driver: a vector table of known conversions, hand-written
// multi-cycle sequences, and random values against an arithmetic reference.
// Two instances share the input: one with leading-zero blanking, one without.
module tb_ssd_bcd_driver;

    localparam int RB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] value_in;
    logic [15:0] bcd_a,  bcd_b;
    logic        busy_a, busy_b;
    logic [3:0]  an_a,   an_b;
    logic [6:0]  led_a,  led_b;

    int n_pass  = 0;
    int n_total = 0;
    int edges   = 0;     // rising edges since the last reset release
    int cur_val = 0;     // value the display should currently show

    typedef struct {
        int          value;
        logic [15:0] exp_bcd;
    } vec_t;

    vec_t vecs[12];

    ssd_bcd_driver #(.REFRESH_BITS(RB), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst_n), .value_in(value_in),
        .bcd_out(bcd_a), .busy(busy_a), .ANODES(an_a), .LED_OUT(led_a)
    );

    ssd_bcd_driver #(.REFRESH_BITS(RB), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst(rst_n), .value_in(value_in),
        .bcd_out(bcd_b), .busy(busy_b), .ANODES(an_b), .LED_OUT(led_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_total);
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] ref_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] ref_led(input int v, input int pos, input bit blank_en);
        int pw;
        pw = 1;
        for (int i = 0; i < pos; i++) pw = pw * 10;
        if (blank_en && pos > 0 && v < pw) return 7'b1111111;
        return ref_seg((v / pw) % 10);
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Wait (bounded) for busy to drop, counting rising edges from the start
    task automatic wait_done(inout int n);
        do begin
            @(posedge clk); #1;
            n++;
        end while (busy_a && n < 40);
    endtask

    // Present a new value while idle and check the full conversion
    task automatic convert(input int v, input string tag);
        int n;
        @(negedge clk);
        value_in = 13'(v);
        @(posedge clk); #1;
        check({tag, "_busy_rise"}, busy_a, 1);
        n = 0;
        wait_done(n);
        check({tag, "_busy_cycles"}, n, 14);
        check({tag, "_bcd"}, bcd_a, ref_bcd(v));
        check({tag, "_bcd_nb"}, bcd_b, ref_bcd(v));
        cur_val = v;
    endtask

    // Watch one full scan frame on both instances
    task automatic check_frame(input string tag);
        int s, d;
        logic [3:0] exp_an;
        @(posedge clk);
        for (int i = 0; i < (1 << RB); i++) begin
            @(negedge clk);
            s      = (edges - 1) % (1 << RB);
            d      = s >> (RB - 2);
            exp_an = ~(4'b0001 << d);
            check({tag, "_anodes"},    an_a,  exp_an);
            check({tag, "_led"},       led_a, ref_led(cur_val, d, 1'b1));
            check({tag, "_anodes_nb"}, an_b,  exp_an);
            check({tag, "_led_nb"},    led_b, ref_led(cur_val, d, 1'b0));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int v;

        vecs[0]  = '{1234, 16'h1234};
        vecs[1]  = '{8191, 16'h8191};
        vecs[2]  = '{0,    16'h0000};
        vecs[3]  = '{9,    16'h0009};
        vecs[4]  = '{10,   16'h0010};
        vecs[5]  = '{99,   16'h0099};
        vecs[6]  = '{100,  16'h0100};
        vecs[7]  = '{999,  16'h0999};
        vecs[8]  = '{1000, 16'h1000};
        vecs[9]  = '{4095, 16'h4095};
        vecs[10] = '{5,    16'h0005};
        vecs[11] = '{8190, 16'h8190};

        // Reset with value_in = 0
        rst_n    = 1'b0;
        value_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bcd",    bcd_a,  16'h0000);
        check("rst_busy",   busy_a, 1'b0);
        check("rst_anodes", an_a,   4'b1111);
        check("rst_led",    led_a,  7'b1111111);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("idle_busy", busy_a, 1'b0);
            check("idle_bcd",  bcd_a,  16'h0000);
        end
        cur_val = 0;
        check_frame("zero_frame");

        // Table-driven conversions, each followed by a display frame
        for (int i = 0; i < 12; i++) begin
            int k;
            k = vecs[i].value;
            @(negedge clk);
            value_in = 13'(k);
            @(posedge clk); #1;
            check("vec_busy_rise", busy_a, 1'b1);
            n = 0;
            wait_done(n);
            check("vec_busy_cycles", n, 14);
            check("vec_bcd", bcd_a, vecs[i].exp_bcd);
            cur_val = k;
            check_frame("vec_frame");
        end

        // Value changes 100 -> 7 during CONV cycle 5
        convert(1, "pre_change");
        @(negedge clk);
        value_in = 13'd100;
        @(posedge clk); #1;
        check("chg_busy_rise", busy_a, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        value_in = 13'd7;
        n = 5;
        wait_done(n);
        check("chg_first_cycles", n, 14);
        check("chg_first_bcd", bcd_a, 16'h0100);
        @(posedge clk); #1;
        check("chg_restart_busy", busy_a, 1'b1);
        n = 0;
        wait_done(n);
        check("chg_second_cycles", n, 14);
        check("chg_second_bcd", bcd_a, 16'h0007);
        cur_val = 7;
        check_frame("chg_frame");

        // Reset pulsed at CONV cycle 8 of a 4095 conversion
        @(negedge clk);
        value_in = 13'd4095;
        @(posedge clk);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_bcd",    bcd_a,  16'h0000);
        check("abort_busy",   busy_a, 1'b0);
        check("abort_anodes", an_a,   4'b1111);
        check("abort_led",    led_a,  7'b1111111);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_restart_busy", busy_a, 1'b1);
        check("abort_no_partial",   bcd_a,  16'h0000);
        n = 0;
        wait_done(n);
        check("abort_cycles", n, 14);
        check("abort_bcd_final", bcd_a, 16'h4095);
        cur_val = 4095;
        check_frame("abort_frame");

        // Value 5: the non-blanking instance lights all four digits
        convert(5, "five");
        check_frame("five_frame");

        // Random values against the reference model
        for (int i = 0; i < 300; i++) begin
            do v = int'($urandom_range(0, 8191)); while (v == cur_val);
            convert(v, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
